pingpong_drain_ctrl: RTL

- Read-side sequencer for pingpong_buffer_sp.
- Waits for a filled half (buf_ready), claims it with a one-cycle buf_take pulse, then streams exactly BUF_LEN samples to a downstream valid/ready consumer (e.g. FFT/feature stage) through a registered output stage.
- Checks block length against rd_last, detects read stalls, counts blocks and buffer overruns.

---
 rtl/pingpong_drain_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/pingpong_drain_ctrl.sv
// Read-side sequencer for a ping-pong buffer: claims a filled half, streams one
// block through a registered valid/ready output stage, and tracks block/error status.
module pingpong_drain_ctrl #(
    parameter int SAMPLE_W = 16,
    parameter int BUF_LEN  = 256,
    parameter int GAP_CYC  = 2,
    parameter int TMO_CYC  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                oneshot_i,
    input  logic                buf_ready_i,
    input  logic                buf_id_i,
    output logic                buf_take_o,
    input  logic [SAMPLE_W-1:0] rd_data_i,
    input  logic                rd_valid_i,
    output logic                rd_ready_o,
    input  logic                rd_last_i,
    input  logic                overrun_i,
    output logic [SAMPLE_W-1:0] m_data_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                m_first_o,
    output logic                m_last_o,
    output logic                m_buf_id_o,
    output logic                busy_o,
    output logic [15:0]         blk_cnt_o,
    output logic [7:0]          ovr_cnt_o,
    output logic                err_len_o,
    output logic                err_tmo_o,
    input  logic                err_clr_i
);

    localparam int IDX_W = $clog2(BUF_LEN) + 1;
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUF_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        TAKE,
        STREAM,
        DRAIN,
        GAP,
        HALT
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t               state;
    state_t               after_block;
    logic [IDX_W-1:0]     idx;
    logic [TMO_W-1:0]     stall_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 oneshot_q;
    logic                 tmo_hit;
    logic                 buf_id_q;
    logic [15:0]          blk_cnt;

    logic [SAMPLE_W-1:0]  data_p1;
    logic                 vld_p1;
    logic                 first_p1;
    logic                 last_p1;

    logic                 ovr_d;
    logic [7:0]           ovr_cnt;
    logic                 err_len;
    logic                 err_tmo;

    logic                 out_free;
    logic                 rd_ready;
    logic                 accept;
    logic                 at_end;
    logic                 blk_end;
    logic                 len_bad;
    logic                 stall_hit;

    assign out_free    = !vld_p1 || m_ready_i;
    assign rd_ready    = (state == STREAM) && out_free;
    assign accept      = rd_valid_i && rd_ready;
    assign at_end      = (idx == IDX_LAST);
    assign blk_end     = accept && (at_end || rd_last_i);
    // rd_last must coincide exactly with the final index; either mismatch is a length error
    assign len_bad     = accept && (rd_last_i != at_end);
    assign stall_hit   = (state == STREAM) && !rd_valid_i && (stall_cnt == TMO_LAST);
    assign after_block = oneshot_q ? HALT : IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx       <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            oneshot_q <= 1'b0;
            tmo_hit   <= 1'b0;
            buf_id_q  <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i && buf_ready_i) begin
                        state <= TAKE;
                    end
                end
                TAKE: begin
                    buf_id_q  <= buf_id_i;
                    oneshot_q <= oneshot_i;
                    idx       <= '0;
                    stall_cnt <= '0;
                    tmo_hit   <= 1'b0;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (rd_valid_i) begin
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                    if (accept) begin
                        idx <= idx + 1'b1;
                    end
                    if (blk_end) begin
                        state <= DRAIN;
                    end else if (stall_hit) begin
                        tmo_hit <= 1'b1;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_free) begin
                        if (!tmo_hit) begin
                            blk_cnt <= blk_cnt + 16'd1;
                        end
                        gap_cnt <= '0;
                        state   <= (GAP_CYC > 0) ? GAP : after_block;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= after_block;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                HALT: begin
                    if (!enable_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage p1: loaded on an accepted read, emptied by a downstream handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else if (accept) begin
            data_p1  <= rd_data_i;
            vld_p1   <= 1'b1;
            first_p1 <= (idx == '0);
            last_p1  <= blk_end;
        end else if (m_ready_i) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovr_d   <= 1'b0;
            ovr_cnt <= '0;
            err_len <= 1'b0;
            err_tmo <= 1'b0;
        end else begin
            ovr_d <= overrun_i;
            if (overrun_i && !ovr_d) begin
                ovr_cnt <= sat_inc8(ovr_cnt);
            end
            if (err_clr_i) begin
                err_len <= 1'b0;
                err_tmo <= 1'b0;
            end else begin
                if (len_bad) begin
                    err_len <= 1'b1;
                end
                if (stall_hit) begin
                    err_tmo <= 1'b1;
                end
            end
        end
    end

    assign buf_take_o = (state == TAKE);
    assign rd_ready_o = rd_ready;
    assign busy_o     = (state != IDLE);
    assign m_data_o   = data_p1;
    assign m_valid_o  = vld_p1;
    assign m_first_o  = first_p1;
    assign m_last_o   = last_p1;
    assign m_buf_id_o = buf_id_q;
    assign blk_cnt_o  = blk_cnt;
    assign ovr_cnt_o  = ovr_cnt;
    assign err_len_o  = err_len;
    assign err_tmo_o  = err_tmo;

endmodule
